// File: rtl/mcp_pkg.sv
// Shared definitions for the multi-cycle-path bus sender: handshake state
// encoding, default geometry and the phase-counter width helper.
package mcp_pkg;

    localparam int DEFAULT_BUS_WIDTH  = 8;
    localparam int DEFAULT_NUM_STAGES = 2;
    localparam int DEFAULT_TIMEOUT    = 255;

    // Four-phase handshake: REQ holds bus_enable high, REL waits for ack to drop.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    // Counter must hold the value TIMEOUT; a disabled timeout still needs one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ack_sync_chain.sv
// Single-bit level synchronizer bringing the destination-domain acknowledge
// into the CLK domain through NUM_STAGES back-to-back flops.
module ack_sync_chain #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_async,
    output logic o_sync
);

    logic [NUM_STAGES-1:0] r_sync;

    // NOTE: every synchronizer flop is reset so a stale ack cannot block in_ready after reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[NUM_STAGES-1];

endmodule

// File: rtl/mcp_bus_sender.sv
// Source side of a multi-cycle-path bus crossing: latches one word, raises a
// level request and runs a four-phase handshake against a synchronized ack.
module mcp_bus_sender
    import mcp_pkg::*;
#(
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    input  logic                 ack_async,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 clear_err
);

    localparam int               CNT_W      = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_bus;
    logic                 r_enable;
    logic                 r_timeout_err;
    logic [CNT_W-1:0]     r_cnt;

    logic w_ack_sync;
    logic w_accept;
    logic w_phase_timeout;

    ack_sync_chain #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .CLK    (CLK),
        .RST    (RST),
        .i_async(ack_async),
        .o_sync (w_ack_sync)
    );

    // A late ack left over from a timed-out transfer keeps the sender closed.
    assign in_ready        = (r_state == IDLE) && !w_ack_sync;
    assign w_accept        = in_valid && in_ready;
    assign w_phase_timeout = TIMEOUT_EN && (r_state != IDLE) && (r_cnt == CNT_MAX);

    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_bus         <= '0;
            r_enable      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // A timeout on the same edge overrides this clear further down.
            if (clear_err) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_bus    <= in_data;
                        r_enable <= 1'b1;
                        r_state  <= REQ;
                        r_cnt    <= '0;
                    end
                end

                REQ: begin
                    if (w_phase_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_enable      <= 1'b0;
                        r_state       <= IDLE;
                        r_cnt         <= '0;
                    end else if (w_ack_sync) begin
                        r_enable <= 1'b0;
                        r_state  <= REL;
                        r_cnt    <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                REL: begin
                    if (w_phase_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_enable      <= 1'b0;
                        r_state       <= IDLE;
                        r_cnt         <= '0;
                    end else if (!w_ack_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_enable <= 1'b0;
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign unsync_bus  = r_bus;
    assign bus_enable  = r_enable;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;

endmodule
